ioctl_upload_reader: RTL and testbench
======================================

Name: ioctl_upload_reader

Overview:
- Reads ROM/RAM contents back out of SDRAM and serves them byte by byte to the host over the ioctl upload interface.
- This is the reverse direction of the download path, which writes ioctl bytes into SDRAM through a toggle-handshake port.
- Sits between data_io (upload side) and one sdram toggle-handshake port (req/ack/a/q), in the clk_sys domain.
- Used for ROM verification dumps and hiscore/NVRAM save.

Parameters:
- ADDR_W, 23, width of the SDRAM word address.
- BASE, 23'h0, word address of the first word read.
- LEN, 25'h28200, number of bytes served per upload; must be at least 1.

Ports:
- clk_sys  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- ioctl_upload  in  1  high while the host upload session is active.
- ioctl_rd  in  1  host byte-consume strobe; rising edge detected internally.
- ioctl_din  out  8  current byte presented to the host.
- ioctl_ready  out  1  ioctl_din is valid.
- byte_cnt  out  25  index of the byte currently presented.
- done  out  1  last byte has been consumed.
- overrun  out  1  sticky; a strobe arrived while not ready or after done.
- mem_req  out  1  toggle request to the sdram port.
- mem_ack  in  1  toggle acknowledge; mem_ack == mem_req means idle or complete.
- mem_a  out  ADDR_W  word address of the request.
- mem_q  in  16  read data; valid when ack matches req.

Behaviour:
- Reset (asynchronous, active high) values:
  - state = IDLE
  - mem_req = 0, mem_a = BASE
  - byte_cnt = 0, ioctl_din = 0
  - ioctl_ready = 0, done = 0, overrun = 0
  - word buffer = 0
  - upload/rd edge registers = 0
- Edge detection: ioctl_upload and ioctl_rd are registered once. Only rising/falling edges of these registered copies act.
- States:
  - IDLE:
    - Rising edge of ioctl_upload: byte_cnt = 0, done = 0, overrun = 0, mem_a = BASE, toggle mem_req, go to FETCH.
    - If mem_ack != mem_req at that edge, go to ABORT_WAIT first and issue the request on leaving it.
  - FETCH:
    - ioctl_ready = 0.
    - On the first cycle mem_ack == mem_req, latch mem_q into the buffer and go to READY.
    - ioctl_ready rises on the next cycle. Minimum latency from request toggle to ready is 2 cycles plus the sdram latency.
  - READY:
    - ioctl_ready = 1.
    - ioctl_din = byte_cnt[0] ? buf[15:8] : buf[7:0], matching the download byte-lane mapping (even byte = low lane).
    - On an rd edge with byte_cnt == LEN-1: done = 1, go to DONE.
    - On any other rd edge: byte_cnt++.
      - If the new byte_cnt[0] == 0: mem_a++, toggle mem_req, go to FETCH.
      - Otherwise stay in READY. The high byte is available the next cycle with no refetch.
  - DONE:
    - ioctl_ready = 0, ioctl_din = 8'hFF.
    - Any rd edge sets overrun.
  - ABORT_WAIT:
    - Hold mem_req; issue no new request until mem_ack == mem_req.
    - Then return to IDLE, or go directly to FETCH if a start is pending.
- Rules that apply in every state:
  - An rd edge in FETCH, IDLE or ABORT_WAIT sets overrun and is otherwise ignored; byte_cnt is unchanged.
  - Falling edge of ioctl_upload in any state:
    - ioctl_ready = 0, byte_cnt = 0.
    - Go to ABORT_WAIT if a request is outstanding, else IDLE.
    - done and overrun hold until the next session start.
  - Simultaneous falling edge of ioctl_upload and an rd edge: the abort wins and the rd edge is ignored (no overrun).
- mem_a arithmetic wraps modulo 2^ADDR_W. byte_cnt never exceeds LEN-1.
- At most one outstanding request at any time. mem_req toggles only when mem_ack == mem_req.

Test Plan:
- Fill words (BASE = 0): 0x1122, 0x3344. Start upload; pulse rd 3 times with an ack delay of 5 cycles. Required:
  - Bytes 0x22, 0x11, 0x44, 0x33 in order.
  - byte_cnt 0, 1, 2, 3.
  - Exactly 2 mem_req toggles observed.
- LEN = 3: consume 3 bytes, then pulse rd again. Required:
  - done = 1, ioctl_ready = 0, ioctl_din = 0xFF.
  - overrun = 1.
  - No third mem_req toggle.
- Pulse rd during FETCH (ack delayed 20 cycles). Required:
  - overrun = 1.
  - byte_cnt unchanged.
  - The byte after ready equals the correctly fetched low byte.
- Drop ioctl_upload while a request is outstanding, then restart immediately. Required:
  - No new mem_req toggle until the stale ack arrives.
  - The restart fetches BASE; byte_cnt = 0.
- Assert reset mid-READY. Required:
  - All outputs return to reset values asynchronously.
  - mem_req = 0.
  - With ioctl_upload held high and no new rising edge, no session starts.

Source files
------------

// File: rtl/ioctl_upload_reader_if.sv
`default_nettype none
// ============================================================================
//  Module      : ioctl_upload_reader_if
//  Description : Bundles the ioctl upload handshake (host side) and the
//                sdram toggle-handshake port used by ioctl_upload_reader.
//                master = the reader itself, slave = host + sdram side.
//  Signals     : ioctl_upload / ioctl_rd        host session and byte strobe
//                ioctl_din / ioctl_ready        byte presented to the host
//                byte_cnt / done / overrun      session status
//                mem_req / mem_a                toggle request and word address
//                mem_ack / mem_q                toggle acknowledge and read data
//  Revision    : 1.0 - initial release
// ============================================================================
interface ioctl_upload_reader_if #(
    parameter int ADDR_W = 23
);
    logic              ioctl_upload;
    logic              ioctl_rd;
    logic [7:0]        ioctl_din;
    logic              ioctl_ready;
    logic [24:0]       byte_cnt;
    logic              done;
    logic              overrun;
    logic              mem_req;
    logic              mem_ack;
    logic [ADDR_W-1:0] mem_a;
    logic [15:0]       mem_q;

    modport master (
        input  ioctl_upload, ioctl_rd, mem_ack, mem_q,
        output ioctl_din, ioctl_ready, byte_cnt, done, overrun, mem_req, mem_a
    );

    modport slave (
        output ioctl_upload, ioctl_rd, mem_ack, mem_q,
        input  ioctl_din, ioctl_ready, byte_cnt, done, overrun, mem_req, mem_a
    );
endinterface
`default_nettype wire

// File: rtl/ioctl_upload_reader.sv
`default_nettype none
// ============================================================================
//  Module      : ioctl_upload_reader
//  Description : Reads LEN bytes starting at SDRAM word address BASE and
//                serves them to the host over the ioctl upload interface,
//                one byte per host read strobe. Each 16-bit word is fetched
//                once; the even byte comes from the low lane, the odd byte
//                from the high lane.
//  Ports       : clk_sys  system clock
//                reset    asynchronous active-high reset
//                bus      ioctl_upload_reader_if.master
//                         (ioctl_upload, ioctl_rd, ioctl_din, ioctl_ready,
//                          byte_cnt, done, overrun, mem_req, mem_ack,
//                          mem_a, mem_q)
//  Revision    : 1.0 - initial release
// ============================================================================
module ioctl_upload_reader #(
    parameter int                ADDR_W = 23,
    parameter logic [ADDR_W-1:0] BASE   = '0,
    parameter logic [24:0]       LEN    = 25'h28200
) (
    input  wire logic             clk_sys,
    input  wire logic             reset,
    ioctl_upload_reader_if.master bus
);

    localparam logic [2:0] c_st_idle  = 3'd0;
    localparam logic [2:0] c_st_fetch = 3'd1;
    localparam logic [2:0] c_st_ready = 3'd2;
    localparam logic [2:0] c_st_done  = 3'd3;
    localparam logic [2:0] c_st_abort = 3'd4;

    localparam logic [24:0] c_last = LEN - 25'd1;

    logic [2:0]        r_state;
    logic              r_primed;
    logic              r_upload_q;
    logic              r_upload_qq;
    logic              r_rd_q;
    logic              r_rd_qq;
    logic              r_start_pending;
    logic              r_mem_req;
    logic [ADDR_W-1:0] r_mem_a;
    logic [24:0]       r_byte_cnt;
    logic              r_done;
    logic              r_overrun;
    logic [15:0]       r_buf;

    logic              w_upload_rise;
    logic              w_upload_fall;
    logic              w_rd_rise;
    logic              w_mem_idle;
    logic [7:0]        w_din;

    // ------------------------------------------------------------------------
    // Input registers. The first cycle after reset loads both history stages
    // with the live input, so a level that was already high when reset was
    // released is not mistaken for a rising edge (a host holding
    // ioctl_upload high across reset does not start a session).
    // ------------------------------------------------------------------------
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            r_primed    <= 1'b0;
            r_upload_q  <= 1'b0;
            r_upload_qq <= 1'b0;
            r_rd_q      <= 1'b0;
            r_rd_qq     <= 1'b0;
        end else if (!r_primed) begin
            r_primed    <= 1'b1;
            r_upload_q  <= bus.ioctl_upload;
            r_upload_qq <= bus.ioctl_upload;
            r_rd_q      <= bus.ioctl_rd;
            r_rd_qq     <= bus.ioctl_rd;
        end else begin
            r_upload_q  <= bus.ioctl_upload;
            r_upload_qq <= r_upload_q;
            r_rd_q      <= bus.ioctl_rd;
            r_rd_qq     <= r_rd_q;
        end
    end

    assign w_upload_rise = r_upload_q & ~r_upload_qq;
    assign w_upload_fall = ~r_upload_q & r_upload_qq;
    assign w_rd_rise     = r_rd_q & ~r_rd_qq;

    // Toggle handshake: the port is idle (or the last read has completed)
    // whenever ack has caught up with req.
    assign w_mem_idle = (bus.mem_ack == r_mem_req);

    // ------------------------------------------------------------------------
    // Session state machine
    // ------------------------------------------------------------------------
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            r_state         <= c_st_idle;
            r_start_pending <= 1'b0;
            r_mem_req       <= 1'b0;
            r_mem_a         <= BASE;
            r_byte_cnt      <= '0;
            r_done          <= 1'b0;
            r_overrun       <= 1'b0;
            r_buf           <= '0;
        end else if (w_upload_fall) begin
            // Session abort wins over everything, including a simultaneous
            // read strobe. done/overrun are left for the host to inspect.
            r_byte_cnt      <= '0;
            r_start_pending <= 1'b0;
            r_state         <= w_mem_idle ? c_st_idle : c_st_abort;
        end else begin
            case (r_state)
                c_st_idle: begin
                    if (w_upload_rise) begin
                        r_byte_cnt <= '0;
                        r_done     <= 1'b0;
                        r_overrun  <= 1'b0;
                        r_mem_a    <= BASE;
                        if (w_mem_idle) begin
                            r_mem_req <= ~r_mem_req;
                            r_state   <= c_st_fetch;
                        end else begin
                            // A read from a previous session is still in
                            // flight; let it drain before issuing ours.
                            r_start_pending <= 1'b1;
                            r_state         <= c_st_abort;
                        end
                    end else if (w_rd_rise) begin
                        r_overrun <= 1'b1;
                    end
                end

                c_st_fetch: begin
                    if (w_rd_rise) begin
                        r_overrun <= 1'b1;
                    end
                    if (w_mem_idle) begin
                        r_buf   <= bus.mem_q;
                        r_state <= c_st_ready;
                    end
                end

                c_st_ready: begin
                    if (w_rd_rise) begin
                        if (r_byte_cnt == c_last) begin
                            r_done  <= 1'b1;
                            r_state <= c_st_done;
                        end else begin
                            r_byte_cnt <= r_byte_cnt + 25'd1;
                            // Leaving an odd (high-lane) byte means the
                            // buffered word is used up: fetch the next one.
                            if (r_byte_cnt[0]) begin
                                r_mem_a   <= r_mem_a + 1'b1;
                                r_mem_req <= ~r_mem_req;
                                r_state   <= c_st_fetch;
                            end
                        end
                    end
                end

                c_st_done: begin
                    if (w_rd_rise) begin
                        r_overrun <= 1'b1;
                    end
                end

                c_st_abort: begin
                    if (w_upload_rise) begin
                        r_byte_cnt      <= '0;
                        r_done          <= 1'b0;
                        r_overrun       <= 1'b0;
                        r_mem_a         <= BASE;
                        r_start_pending <= 1'b1;
                    end else if (w_rd_rise) begin
                        r_overrun <= 1'b1;
                    end
                    if (w_mem_idle) begin
                        if (r_start_pending || w_upload_rise) begin
                            r_start_pending <= 1'b0;
                            r_mem_req       <= ~r_mem_req;
                            r_state         <= c_st_fetch;
                        end else begin
                            r_state <= c_st_idle;
                        end
                    end
                end

                default: begin
                    r_state <= c_st_idle;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Byte presentation
    // ------------------------------------------------------------------------
    always_comb begin
        w_din = 8'h00;
        if (r_state == c_st_ready) begin
            w_din = r_byte_cnt[0] ? r_buf[15:8] : r_buf[7:0];
        end else if (r_state == c_st_done) begin
            w_din = 8'hFF;
        end
    end

    assign bus.ioctl_din   = w_din;
    assign bus.ioctl_ready = (r_state == c_st_ready);
    assign bus.byte_cnt    = r_byte_cnt;
    assign bus.done        = r_done;
    assign bus.overrun     = r_overrun;
    assign bus.mem_req     = r_mem_req;
    assign bus.mem_a       = r_mem_a;

endmodule
`default_nettype wire

// File: tb/tb_ioctl_upload_reader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ioctl_upload_reader
//  Description : Self-checking bench for ioctl_upload_reader. A toggle-
//                handshake SDRAM model serves words from a reference array;
//                expected bytes are queued by the stimulus and compared by an
//                independent monitor whenever the DUT presents a new byte.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ioctl_upload_reader;

    localparam int                ADDR_W = 23;
    localparam logic [ADDR_W-1:0] BASE   = '0;
    localparam int                LEN    = 5;

    typedef struct packed {
        logic [24:0] idx;
        logic [7:0]  data;
    } exp_t;

    logic clk_sys = 1'b0;
    logic reset;

    always #5 clk_sys = ~clk_sys;

    ioctl_upload_reader_if #(.ADDR_W(ADDR_W)) bus ();

    ioctl_upload_reader #(
        .ADDR_W (ADDR_W),
        .BASE   (BASE),
        .LEN    (25'(LEN))
    ) u_dut (
        .clk_sys (clk_sys),
        .reset   (reset),
        .bus     (bus)
    );

    int          checks = 0;
    int          errors = 0;
    int          toggles = 0;
    int          ack_delay = 1;
    logic [15:0] mem_model [0:15];
    exp_t        exp_q [$];

    // ------------------------------------------------------------------------
    // Reference helpers
    // ------------------------------------------------------------------------
    function automatic logic [7:0] ref_byte(input int k);
        logic [15:0] w;
        w = mem_model[(int'(BASE) + k / 2) & 15];
        return (k % 2 == 1) ? w[15:8] : w[7:0];
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h required %0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic push_exp(input int k);
        exp_t e;
        e.idx  = 25'(k);
        e.data = ref_byte(k);
        exp_q.push_back(e);
    endtask

    task automatic randomize_mem();
        for (int i = 0; i < 16; i++) mem_model[i] = 16'($urandom);
        if (mem_model[1] == mem_model[0]) mem_model[1] = ~mem_model[0];
    endtask

    // ------------------------------------------------------------------------
    // SDRAM toggle-handshake model
    // ------------------------------------------------------------------------
    logic [ADDR_W-1:0] sd_a;
    logic              sd_r;

    initial begin
        bus.mem_ack = 1'b0;
        bus.mem_q   = 16'h0;
        forever begin
            @(negedge clk_sys);
            if (reset) begin
                bus.mem_ack = 1'b0;
            end else if (bus.mem_req != bus.mem_ack) begin
                sd_a = bus.mem_a;
                sd_r = bus.mem_req;
                repeat (ack_delay) @(negedge clk_sys);
                #1;
                bus.mem_q   = mem_model[sd_a[3:0]];
                bus.mem_ack = sd_r;
            end
        end
    end

    // Request toggles: counted, and each one must start from an idle port.
    logic pre_req, pre_ack;
    initial begin
        forever begin
            @(posedge clk_sys);
            pre_req = bus.mem_req;
            pre_ack = bus.mem_ack;
            #1;
            if (!reset && bus.mem_req != pre_req) begin
                toggles++;
                check("req_toggle_from_idle", 32'(pre_ack), 32'(pre_req));
            end
        end
    end

    // Scoreboard monitor: one pop per newly presented byte.
    logic        prev_ready;
    logic [24:0] prev_cnt;
    exp_t        mon_e;
    initial begin
        prev_ready = 1'b0;
        prev_cnt   = '0;
        forever begin
            @(negedge clk_sys);
            if (bus.ioctl_ready && (!prev_ready || bus.byte_cnt != prev_cnt)) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_byte: got idx %0d data %0h required none", bus.byte_cnt, bus.ioctl_din);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("byte_idx", 32'(bus.byte_cnt), 32'(mon_e.idx));
                    check("byte_data", 32'(bus.ioctl_din), 32'(mon_e.data));
                end
            end
            prev_ready = bus.ioctl_ready;
            prev_cnt   = bus.byte_cnt;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // ------------------------------------------------------------------------
    // Host driver tasks
    // ------------------------------------------------------------------------
    task automatic pulse_rd();
        @(negedge clk_sys) bus.ioctl_rd = 1'b1;
        @(negedge clk_sys) bus.ioctl_rd = 1'b0;
    endtask

    task automatic wait_present(input int k);
        bit found = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk_sys);
            if (bus.ioctl_ready && bus.byte_cnt == 25'(k)) begin
                found = 1'b1;
                break;
            end
        end
        if (!found) begin
            checks++;
            errors++;
            $display("FAIL wait_present: byte %0d not presented, got idx %0d ready %0b", k, bus.byte_cnt, bus.ioctl_ready);
        end
    endtask

    task automatic wait_done();
        bit found = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk_sys);
            if (bus.done) begin
                found = 1'b1;
                break;
            end
        end
        if (!found) begin
            checks++;
            errors++;
            $display("FAIL wait_done: got done %0b required 1", bus.done);
        end
    endtask

    task automatic wait_port_idle();
        for (int i = 0; i < 400; i++) begin
            @(negedge clk_sys);
            if (bus.mem_req == bus.mem_ack) break;
        end
    endtask

    // Start a session and consume n bytes (n == LEN runs to done).
    task automatic session(input int n);
        push_exp(0);
        @(negedge clk_sys) bus.ioctl_upload = 1'b1;
        for (int k = 0; k < n; k++) begin
            wait_present(k);
            if (k + 1 < LEN) push_exp(k + 1);
            repeat ($urandom_range(0, 3)) @(negedge clk_sys);
            pulse_rd();
        end
        if (n < LEN) wait_present(n);
        else         wait_done();
    endtask

    task automatic end_session();
        @(negedge clk_sys) bus.ioctl_upload = 1'b0;
        repeat (3) @(negedge clk_sys);
        check("end_ready", 32'(bus.ioctl_ready), 32'd0);
        check("end_byte_cnt", 32'(bus.byte_cnt), 32'd0);
        wait_port_idle();
        repeat (3) @(negedge clk_sys);
    endtask

    // ------------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------------
    int t0;
    int n;
    int last;

    initial begin
        reset            = 1'b1;
        bus.ioctl_upload = 1'b0;
        bus.ioctl_rd     = 1'b0;
        randomize_mem();
        repeat (3) @(negedge clk_sys);
        reset = 1'b0;
        repeat (2) @(negedge clk_sys);

        // Reset state
        check("rst_ready", 32'(bus.ioctl_ready), 32'd0);
        check("rst_din", 32'(bus.ioctl_din), 32'd0);
        check("rst_byte_cnt", 32'(bus.byte_cnt), 32'd0);
        check("rst_done", 32'(bus.done), 32'd0);
        check("rst_overrun", 32'(bus.overrun), 32'd0);
        check("rst_mem_req", 32'(bus.mem_req), 32'd0);
        check("rst_mem_a", 32'(bus.mem_a), 32'(BASE));

        // Known words, 3 strobes, ack delay 5: bytes 22 11 44 33, 2 fetches
        mem_model[0] = 16'h1122;
        mem_model[1] = 16'h3344;
        ack_delay    = 5;
        t0 = toggles;
        session(3);
        check("t1_toggles", 32'(toggles - t0), 32'd2);
        end_session();

        // Full session to done, then one extra strobe
        randomize_mem();
        ack_delay = $urandom_range(0, 6);
        t0 = toggles;
        session(LEN);
        check("t2_done", 32'(bus.done), 32'd1);
        check("t2_ready", 32'(bus.ioctl_ready), 32'd0);
        check("t2_din", 32'(bus.ioctl_din), 32'hFF);
        check("t2_overrun_before", 32'(bus.overrun), 32'd0);
        check("t2_toggles", 32'(toggles - t0), 32'((LEN + 1) / 2));
        pulse_rd();
        repeat (4) @(negedge clk_sys);
        check("t2_overrun_after", 32'(bus.overrun), 32'd1);
        check("t2_byte_cnt", 32'(bus.byte_cnt), 32'(LEN - 1));
        check("t2_no_extra_toggle", 32'(toggles - t0), 32'((LEN + 1) / 2));
        end_session();
        check("t2_done_held", 32'(bus.done), 32'd1);
        check("t2_overrun_held", 32'(bus.overrun), 32'd1);

        // Strobe during a slow fetch
        randomize_mem();
        ack_delay = 20;
        push_exp(0);
        @(negedge clk_sys) bus.ioctl_upload = 1'b1;
        repeat (4) @(negedge clk_sys);
        check("t3_overrun_cleared", 32'(bus.overrun), 32'd0);
        check("t3_done_cleared", 32'(bus.done), 32'd0);
        check("t3_fetch_not_ready", 32'(bus.ioctl_ready), 32'd0);
        pulse_rd();
        repeat (3) @(negedge clk_sys);
        check("t3_overrun", 32'(bus.overrun), 32'd1);
        check("t3_byte_cnt", 32'(bus.byte_cnt), 32'd0);
        wait_present(0);
        end_session();

        // Abort with a request outstanding, restart immediately
        randomize_mem();
        ack_delay = 15;
        @(negedge clk_sys) bus.ioctl_upload = 1'b1;
        repeat (4) @(negedge clk_sys);
        check("t4_outstanding", 32'(bus.mem_req != bus.mem_ack), 32'd1);
        t0 = toggles;
        @(negedge clk_sys) bus.ioctl_upload = 1'b0;
        push_exp(0);
        @(negedge clk_sys) bus.ioctl_upload = 1'b1;
        repeat (6) @(negedge clk_sys);
        check("t4_no_toggle_while_stale", 32'(toggles - t0), 32'd0);
        check("t4_byte_cnt", 32'(bus.byte_cnt), 32'd0);
        check("t4_mem_a", 32'(bus.mem_a), 32'(BASE));
        wait_present(0);
        check("t4_one_restart_toggle", 32'(toggles - t0), 32'd1);
        push_exp(1);
        pulse_rd();
        wait_present(1);
        end_session();

        // Asynchronous reset in READY, upload held high afterwards
        randomize_mem();
        ack_delay = 2;
        push_exp(0);
        @(negedge clk_sys) bus.ioctl_upload = 1'b1;
        wait_present(0);
        push_exp(1);
        pulse_rd();
        wait_present(1);
        check("t5_req_before", 32'(bus.mem_req), 32'd1);
        @(negedge clk_sys);
        #3 reset = 1'b1;
        #1;
        check("t5_ready", 32'(bus.ioctl_ready), 32'd0);
        check("t5_din", 32'(bus.ioctl_din), 32'd0);
        check("t5_byte_cnt", 32'(bus.byte_cnt), 32'd0);
        check("t5_done", 32'(bus.done), 32'd0);
        check("t5_overrun", 32'(bus.overrun), 32'd0);
        check("t5_mem_req", 32'(bus.mem_req), 32'd0);
        check("t5_mem_a", 32'(bus.mem_a), 32'(BASE));
        repeat (2) @(negedge clk_sys);
        reset = 1'b0;
        t0 = toggles;
        repeat (20) @(negedge clk_sys);
        check("t5_no_session_toggles", 32'(toggles - t0), 32'd0);
        check("t5_no_session_req", 32'(bus.mem_req), 32'd0);
        check("t5_no_session_ready", 32'(bus.ioctl_ready), 32'd0);
        @(negedge clk_sys) bus.ioctl_upload = 1'b0;
        repeat (4) @(negedge clk_sys);

        // Randomized sessions
        for (int s = 0; s < 6; s++) begin
            randomize_mem();
            ack_delay = $urandom_range(0, 8);
            n         = $urandom_range(1, LEN);
            last      = (n < LEN) ? n : LEN - 1;
            t0        = toggles;
            session(n);
            check("rand_toggles", 32'(toggles - t0), 32'(last / 2 + 1));
            check("rand_done", 32'(bus.done), 32'(n == LEN));
            end_session();
        end

        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
